// File: rtl/dw_ram_nr_nw_s_dff.sv
// dw_ram_nr_nw_s_dff: flip-flop register file with num_wr write ports and
// num_rd registered read ports. Highest-numbered write port wins on an address
// clash; out-of-range accesses are dropped (writes) or read back as zero.
// Optional build macro DW_RAM_NRNW_WRITE_BYPASS_EN: a read that hits a word
// being written on the same edge returns the new data instead of the old word.
module dw_ram_nr_nw_s_dff #(
  parameter int width      = 8,
  parameter int addr_width = 3,
  parameter int depth      = 8,
  parameter int num_wr     = 2,
  parameter int num_rd     = 2,
  parameter int rst_mode   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [num_wr-1:0]            en_w_n,
  input  logic [num_wr*addr_width-1:0] addr_w,
  input  logic [num_wr*width-1:0]      data_w,
  input  logic [num_rd-1:0]            en_r_n,
  input  logic [num_rd*addr_width-1:0] addr_r,
  output logic [num_rd*width-1:0]      data_r,
  output logic [num_rd-1:0]            valid_r,
  output logic                         wr_collision,
  output logic                         addr_err
);

`ifdef DW_RAM_NRNW_WRITE_BYPASS_EN
  localparam bit bypass_en = 1'b1;
`else
  localparam bit bypass_en = 1'b0;
`endif

  // One extra bit so depth == 2**addr_width is representable.
  localparam logic [addr_width:0] depth_lim = (addr_width + 1)'(depth);

  logic [width-1:0]      mem_reg   [depth];
  logic [width-1:0]      mem_next  [depth];

  logic [addr_width-1:0] wr_addr   [num_wr];
  logic [width-1:0]      wr_data   [num_wr];
  logic [num_wr-1:0]     wr_ok;
  logic [num_wr-1:0]     wr_oor;

  logic [addr_width-1:0] rd_addr   [num_rd];
  logic [num_rd-1:0]     rd_ok;
  logic [num_rd-1:0]     rd_oor;
  logic [width-1:0]      rd_word   [num_rd];

  logic [width-1:0]      data_r_reg [num_rd];
  logic [num_rd-1:0]     valid_r_reg;
  logic                  wr_collision_reg;
  logic                  wr_collision_next;
  logic                  addr_err_reg;
  logic                  addr_err_next;

  genvar gi;

  // Unpack write ports and classify each as in-range or out-of-range.
  generate
    for (gi = 0; gi < num_wr; gi++) begin : g_wr
      assign wr_addr[gi] = addr_w[gi*addr_width +: addr_width];
      assign wr_data[gi] = data_w[gi*width +: width];
      assign wr_ok[gi]   = ~en_w_n[gi] & ({1'b0, wr_addr[gi]} <  depth_lim);
      assign wr_oor[gi]  = ~en_w_n[gi] & ({1'b0, wr_addr[gi]} >= depth_lim);
    end
  endgenerate

  // Unpack read ports and drive the packed outputs from the registers.
  generate
    for (gi = 0; gi < num_rd; gi++) begin : g_rd
      assign rd_addr[gi] = addr_r[gi*addr_width +: addr_width];
      assign rd_ok[gi]   = ~en_r_n[gi] & ({1'b0, rd_addr[gi]} <  depth_lim);
      assign rd_oor[gi]  = ~en_r_n[gi] & ({1'b0, rd_addr[gi]} >= depth_lim);
      assign data_r[gi*width +: width] = data_r_reg[gi];
    end
  endgenerate

  assign valid_r      = valid_r_reg;
  assign wr_collision = wr_collision_reg;
  assign addr_err     = addr_err_reg;

  // Next array contents: later ports overwrite earlier ones, so the
  // highest-numbered enabled port wins a shared address.
  always_comb begin
    for (int w = 0; w < depth; w++) begin
      mem_next[w] = mem_reg[w];
    end
    for (int k = 0; k < num_wr; k++) begin
      for (int w = 0; w < depth; w++) begin
        if (wr_ok[k] && (wr_addr[k] == addr_width'(w))) begin
          mem_next[w] = wr_data[k];
        end
      end
    end
  end

  // Flag any pair of enabled in-range writes that share an address.
  always_comb begin
    wr_collision_next = 1'b0;
    for (int j = 0; j < num_wr; j++) begin
      for (int k = j + 1; k < num_wr; k++) begin
        if (wr_ok[j] && wr_ok[k] && (wr_addr[j] == wr_addr[k])) begin
          wr_collision_next = 1'b1;
        end
      end
    end
  end

  // Read mux per port; out-of-range addresses fall through to zero.
  always_comb begin
    for (int r = 0; r < num_rd; r++) begin
      rd_word[r] = '0;
      for (int w = 0; w < depth; w++) begin
        if (rd_ok[r] && (rd_addr[r] == addr_width'(w))) begin
          rd_word[r] = bypass_en ? mem_next[w] : mem_reg[w];
        end
      end
    end
  end

  assign addr_err_next = (|wr_oor) | (|rd_oor);

  // Array and output registers; reset discards every access in that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < num_rd; r++) begin
        data_r_reg[r] <= '0;
      end
      valid_r_reg      <= '0;
      wr_collision_reg <= 1'b0;
      addr_err_reg     <= 1'b0;
      if (rst_mode == 0) begin
        for (int w = 0; w < depth; w++) begin
          mem_reg[w] <= '0;
        end
      end
    end else begin
      for (int w = 0; w < depth; w++) begin
        mem_reg[w] <= mem_next[w];
      end
      for (int r = 0; r < num_rd; r++) begin
        if (!en_r_n[r]) begin
          data_r_reg[r]  <= rd_word[r];
          valid_r_reg[r] <= 1'b1;
        end else begin
          valid_r_reg[r] <= 1'b0;
        end
      end
      wr_collision_reg <= wr_collision_next;
      addr_err_reg     <= addr_err_next;
    end
  end

endmodule

// File: tb/tb_dw_ram_nr_nw_s_dff.sv
// Directed bench for dw_ram_nr_nw_s_dff: two instances (rst_mode 0 and 1)
// share the same stimulus so both reset flavours are checked together.
module tb_dw_ram_nr_nw_s_dff;

  localparam int W  = 8;
  localparam int AW = 3;
  localparam int D  = 6;
  localparam int NW = 2;
  localparam int NR = 2;

`ifdef DW_RAM_NRNW_WRITE_BYPASS_EN
  localparam bit bypass = 1'b1;
`else
  localparam bit bypass = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NW-1:0]     en_w_n;
  logic [NW*AW-1:0]  addr_w;
  logic [NW*W-1:0]   data_w;
  logic [NR-1:0]     en_r_n;
  logic [NR*AW-1:0]  addr_r;

  logic [NR*W-1:0]   data_r0, data_r1;
  logic [NR-1:0]     valid_r0, valid_r1;
  logic              coll0, coll1;
  logic              err0, err1;

  int n_checks;
  int n_fail;

  dw_ram_nr_nw_s_dff #(
    .width(W), .addr_width(AW), .depth(D), .num_wr(NW), .num_rd(NR), .rst_mode(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en_w_n(en_w_n), .addr_w(addr_w), .data_w(data_w),
    .en_r_n(en_r_n), .addr_r(addr_r), .data_r(data_r0), .valid_r(valid_r0),
    .wr_collision(coll0), .addr_err(err0)
  );

  dw_ram_nr_nw_s_dff #(
    .width(W), .addr_width(AW), .depth(D), .num_wr(NW), .num_rd(NR), .rst_mode(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en_w_n(en_w_n), .addr_w(addr_w), .data_w(data_w),
    .en_r_n(en_r_n), .addr_r(addr_r), .data_r(data_r1), .valid_r(valid_r1),
    .wr_collision(coll1), .addr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    en_w_n = '1;
    en_r_n = '1;
    addr_w = '0;
    data_w = '0;
    addr_r = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 1'b0;
    tick();
    check_eq("rst_data0",  32'(data_r0),  32'h0);
    check_eq("rst_valid0", 32'(valid_r0), 32'h0);
    check_eq("rst_coll0",  32'(coll0),    32'h0);
    check_eq("rst_err0",   32'(err0),     32'h0);
    rst_n = 1'b1;

    // Fill every word with 0xFF, two words per cycle.
    for (int a = 0; a < D; a += 2) begin
      en_w_n = 2'b00;
      addr_w = {3'(a + 1), 3'(a)};
      data_w = 16'hFFFF;
      tick();
      check_eq("fill_coll", 32'(coll0), 32'h0);
    end

    // Reset: rst_mode 0 clears, rst_mode 1 keeps 0xFF.
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < D; a += 2) begin
      en_r_n = 2'b00;
      addr_r = {3'(a + 1), 3'(a)};
      tick();
      check_eq("t1_data_mode0",  32'(data_r0),  32'h0000);
      check_eq("t1_data_mode1",  32'(data_r1),  32'hFFFF);
      check_eq("t1_valid_mode0", 32'(valid_r0), 32'h3);
      check_eq("t1_valid_mode1", 32'(valid_r1), 32'h3);
    end
    idle();
    tick();
    check_eq("t1_valid_drop", 32'(valid_r0), 32'h0);
    check_eq("t1_data_hold",  32'(data_r1),  32'hFFFF);

    // Two writes to distinct addresses commit together.
    en_w_n = 2'b00;
    addr_w = {3'd5, 3'd2};
    data_w = {8'h22, 8'h11};
    tick();
    check_eq("t2_coll", 32'(coll0), 32'h0);
    idle();
    en_r_n = 2'b00;
    addr_r = {3'd5, 3'd2};
    tick();
    check_eq("t2_data_mode0", 32'(data_r0), 32'h2211);
    check_eq("t2_data_mode1", 32'(data_r1), 32'h2211);

    // Same-address writes: port 1 wins, one-cycle collision pulse.
    idle();
    en_w_n = 2'b00;
    addr_w = {3'd3, 3'd3};
    data_w = {8'h55, 8'hAA};
    tick();
    check_eq("t3_coll_set0", 32'(coll0), 32'h1);
    check_eq("t3_coll_set1", 32'(coll1), 32'h1);
    idle();
    en_r_n = 2'b00;
    addr_r = {3'd3, 3'd3};
    tick();
    check_eq("t3_coll_clr", 32'(coll0), 32'h0);
    check_eq("t3_data",     32'(data_r0), 32'h5555);

    // Read-during-write on addr1 through port 0; port 1 holds 0x55.
    idle();
    en_w_n = 2'b10;
    addr_w = {3'd0, 3'd1};
    data_w = {8'h00, 8'h3C};
    en_r_n = 2'b10;
    addr_r = {3'd0, 3'd1};
    tick();
    check_eq("t4_rdw_mode0", 32'(data_r0), bypass ? 32'h553C : 32'h5500);
    check_eq("t4_rdw_mode1", 32'(data_r1), bypass ? 32'h553C : 32'h55FF);
    check_eq("t4_valid",     32'(valid_r0), 32'h1);
    idle();
    en_r_n = 2'b10;
    addr_r = {3'd0, 3'd1};
    tick();
    check_eq("t4_after_mode0", 32'(data_r0[7:0]), 32'h3C);
    check_eq("t4_after_mode1", 32'(data_r1[7:0]), 32'h3C);

    // Out-of-range write only.
    idle();
    en_w_n = 2'b10;
    addr_w = {3'd0, 3'd6};
    data_w = {8'h00, 8'h77};
    tick();
    check_eq("t5_werr", 32'(err0), 32'h1);
    // Out-of-range read only.
    idle();
    en_r_n = 2'b10;
    addr_r = {3'd0, 3'd7};
    tick();
    check_eq("t5_rerr",   32'(err0),          32'h1);
    check_eq("t5_rdata",  32'(data_r0[7:0]),  32'h00);
    check_eq("t5_rvalid", 32'(valid_r0),      32'h1);
    check_eq("t5_coll",   32'(coll0),         32'h0);
    idle();
    tick();
    check_eq("t5_err_clr", 32'(err0), 32'h0);
    en_r_n = 2'b00;
    addr_r = {3'd4, 3'd2};
    tick();
    check_eq("t5_array_mode0", 32'(data_r0), 32'h0011);
    check_eq("t5_array_mode1", 32'(data_r1), 32'hFF11);

    // Write addr0=0x10, then reset on the same edge as a 0x99 write.
    idle();
    en_w_n = 2'b10;
    addr_w = {3'd0, 3'd0};
    data_w = {8'h00, 8'h10};
    tick();
    en_w_n = 2'b00;
    addr_w = {3'd0, 3'd0};
    data_w = {8'h99, 8'h99};
    en_r_n = 2'b00;
    addr_r = {3'd7, 3'd0};
    rst_n  = 1'b0;
    tick();
    check_eq("t6_data",  32'(data_r1),  32'h0);
    check_eq("t6_valid", 32'(valid_r1), 32'h0);
    check_eq("t6_coll",  32'(coll1),    32'h0);
    check_eq("t6_err",   32'(err1),     32'h0);
    rst_n = 1'b1;
    idle();
    en_r_n = 2'b10;
    addr_r = {3'd0, 3'd0};
    tick();
    check_eq("t6_keep_mode1",  32'(data_r1[7:0]), 32'h10);
    check_eq("t6_clear_mode0", 32'(data_r0[7:0]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
